des_cbc_ctrl: RTL and testbench

Block-mode controller that sits between the host and `des_top`. It accepts 64-bit blocks over a valid/ready handshake and chains them in CBC mode. It drives one block at a time into the core's `plain_text`/`valid_in`, captures `cipher_text` on `valid_out`, applies the CBC XOR, and returns the result over a second valid/ready handshake. A watchdog flags a core that never answers.

---
 rtl/des_cbc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_des_cbc_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: block-mode controller between a host stream and des_top.
//
// Takes 64-bit blocks over s_valid/s_ready, sends one block at a time to the
// DES core, captures the core answer, applies the CBC XOR and returns the
// result over m_valid/m_ready. A watchdog raises a sticky err when the core
// does not answer in time.
//
// Build option: define DES_CBC_CHAIN_EN for CBC chaining. With the macro
// undefined the block runs in ECB mode: there is no chain register and iv is
// ignored. iv_load then only clears err and no longer holds off s_ready.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   decrypt                    0 = encrypt, 1 = decrypt (sampled on input handshake)
//   iv, iv_load                initialisation vector and its load pulse (IDLE only)
//   s_valid/s_ready/s_data     host input block
//   m_valid/m_ready/m_data     result block
//   core_plain_text, core_valid_in, core_encrypt_decrypt   to des_top
//   core_cipher_text, core_valid_out                       from des_top
//   err                        sticky watchdog error
module des_cbc_ctrl #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        decrypt,
  input  logic [63:0] iv,
  input  logic        iv_load,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic [63:0] core_plain_text,
  output logic        core_valid_in,
  output logic        core_encrypt_decrypt,
  input  logic [63:0] core_cipher_text,
  input  logic        core_valid_out,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Timeout fires when the incremented count lands on this value.
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  wdog_q;
  logic [7:0]  wdog_d;
  logic [63:0] blk_q;
  logic        mode_q;
  logic [63:0] m_data_q;
  logic        m_valid_q;
  logic        core_valid_in_q;
  logic [63:0] core_plain_text_q;
  logic        err_q;
  logic [63:0] plain_d;
  logic [63:0] result_d;
`ifdef DES_CBC_CHAIN_EN
  logic [63:0] chain_q;
  logic [63:0] chain_d;
`else
  logic        unused_s;
  assign unused_s = ^{iv, blk_q};
`endif

  // Next-value datapath: core input, CBC result and chain update.
  always_comb begin
    wdog_d = wdog_q + 8'd1;
`ifdef DES_CBC_CHAIN_EN
    // decrypt is used directly because mode is latched on this same edge.
    plain_d  = decrypt ? s_data : (s_data ^ chain_q);
    result_d = mode_q ? (core_cipher_text ^ chain_q) : core_cipher_text;
    chain_d  = mode_q ? blk_q : core_cipher_text;
`else
    plain_d  = s_data;
    result_d = core_cipher_text;
`endif
  end

  // Input ready depends on state only (plus iv_load priority in CBC builds).
`ifdef DES_CBC_CHAIN_EN
  assign s_ready = rstn && (state_q == IDLE) && !iv_load;
`else
  assign s_ready = rstn && (state_q == IDLE);
`endif

  // Controller FSM with all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= IDLE;
      wdog_q            <= 8'd0;
      blk_q             <= 64'd0;
      mode_q            <= 1'b0;
      m_data_q          <= 64'd0;
      m_valid_q         <= 1'b0;
      core_valid_in_q   <= 1'b0;
      core_plain_text_q <= 64'd0;
      err_q             <= 1'b0;
`ifdef DES_CBC_CHAIN_EN
      chain_q           <= 64'd0;
`endif
    end else begin
      core_valid_in_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iv_load) begin
            err_q   <= 1'b0;
`ifdef DES_CBC_CHAIN_EN
            chain_q <= iv;
`endif
          end
          if (s_valid && s_ready) begin
            blk_q             <= s_data;
            mode_q            <= decrypt;
            core_plain_text_q <= plain_d;
            core_valid_in_q   <= 1'b1;
            state_q           <= ISSUE;
          end
        end
        ISSUE: begin
          wdog_q  <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (core_valid_out) begin
            m_data_q  <= result_d;
            m_valid_q <= 1'b1;
`ifdef DES_CBC_CHAIN_EN
            chain_q   <= chain_d;
`endif
            state_q   <= OUT;
          end else if (wdog_d == WDOG_LAST) begin
            // Give up on the core: chain is left untouched, nothing is output.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_valid              = m_valid_q;
  assign m_data               = m_data_q;
  assign core_valid_in        = core_valid_in_q;
  assign core_plain_text      = core_plain_text_q;
  assign core_encrypt_decrypt = mode_q;
  assign err                  = err_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl with a small invertible core stub.
// The stub stands in for des_top: encrypt = rotl8(x) ^ KEY, decrypt undoes it,
// answering STUB_LAT cycles after core_valid_in. Expectations follow the CBC
// or ECB behaviour depending on DES_CBC_CHAIN_EN.
module tb_des_cbc_ctrl;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] P   = 64'h0123456789ABCDEF;
  // Hand-computed: rotl8(P) ^ KEY = 23456789ABCDEF01 ^ 133457799BBCDFF1.
  localparam logic [63:0] C1  = 64'h307130F0307130F0;
  localparam int STUB_LAT = 3;
`ifdef DES_CBC_CHAIN_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] iv = 64'd0;
  logic        iv_load = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = 64'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [63:0] core_plain_text;
  logic        core_valid_in;
  logic        core_encrypt_decrypt;
  logic [63:0] core_cipher_text = 64'd0;
  logic        core_valid_out = 1'b0;
  logic        err;

  logic [63:0] chain_m = 64'd0;
  logic [63:0] c2_m = 64'd0;
  bit          stub_en = 1'b1;
  bit          stub_pend = 1'b0;
  int          stub_cnt = 0;
  logic [63:0] stub_res = 64'd0;

  des_cbc_ctrl #(.WDOG_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .decrypt(decrypt), .iv(iv), .iv_load(iv_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_plain_text(core_plain_text), .core_valid_in(core_valid_in),
    .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_cipher_text(core_cipher_text), .core_valid_out(core_valid_out),
    .err(err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] stub_enc(input logic [63:0] x);
    return {x[55:0], x[63:56]} ^ KEY;
  endfunction

  function automatic logic [63:0] stub_dec(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ KEY;
    return {y[7:0], y[63:8]};
  endfunction

  // Core stub: one request at a time, not affected by the DUT reset.
  always @(posedge clk) begin
    core_valid_out <= 1'b0;
    if (stub_pend) begin
      if (stub_cnt == 0) begin
        core_valid_out   <= 1'b1;
        core_cipher_text <= stub_res;
        stub_pend        <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
    if (core_valid_in && stub_en) begin
      stub_pend <= 1'b1;
      stub_cnt  <= STUB_LAT - 2;
      stub_res  <= core_encrypt_decrypt ? stub_dec(core_plain_text) : stub_enc(core_plain_text);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and return one step past the handshake edge (ISSUE cycle).
  task automatic send_block(input logic [63:0] d, input logic dec, output bit ok);
    s_data  = d;
    decrypt = dec;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output bit seen, output bit cvo_prev);
    seen     = 1'b0;
    cvo_prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      cvo_prev = core_valid_out;
      tick();
    end
  endtask

  task automatic take_out();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({s_ready, m_valid, core_valid_in, core_encrypt_decrypt, err} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {s_ready, m_valid, core_valid_in, core_encrypt_decrypt, err});
    end
    checks++;
    if ({m_data, core_plain_text} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h expected zero", m_data, core_plain_text);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", s_ready);
    end
    tick();
  endtask

  task automatic test_encrypt();
    bit ok, seen, cvo_prev;
    send_block(P, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL enc_accept: got 0 expected 1"); end
    checks++;
    if (core_valid_in !== 1'b1) begin errors++; $display("FAIL enc_issue: got %b expected 1", core_valid_in); end
    checks++;
    if (core_plain_text !== P) begin errors++; $display("FAIL enc_plain: got %h expected %h", core_plain_text, P); end
    checks++;
    if (core_encrypt_decrypt !== 1'b0) begin errors++; $display("FAIL enc_mode: got %b expected 0", core_encrypt_decrypt); end
    tick();
    checks++;
    if (core_valid_in !== 1'b0) begin errors++; $display("FAIL enc_issue_once: got %b expected 0", core_valid_in); end
    wait_out(seen, cvo_prev);
    checks++;
    if (!seen) begin errors++; $display("FAIL enc_timeout: got no m_valid expected m_valid"); end
    checks++;
    if (cvo_prev !== 1'b1) begin errors++; $display("FAIL enc_mvalid_timing: got %b expected 1", cvo_prev); end
    checks++;
    if (m_data !== C1) begin errors++; $display("FAIL enc_result: got %h expected %h", m_data, C1); end
    take_out();
    chain_m = C1;
    checks++;
    if ({m_valid, s_ready} !== 2'b01) begin errors++; $display("FAIL enc_release: got %b expected 01", {m_valid, s_ready}); end
  endtask

  task automatic test_chain();
    bit ok, seen, cvo_prev;
    logic [63:0] exp_in;
    exp_in = CBC ? (P ^ chain_m) : P;
    send_block(P, 1'b0, ok);
    checks++;
    if (core_plain_text !== exp_in) begin errors++; $display("FAIL chain_plain: got %h expected %h", core_plain_text, exp_in); end
    wait_out(seen, cvo_prev);
    c2_m = stub_enc(exp_in);
    checks++;
    if (!seen || m_data !== c2_m) begin errors++; $display("FAIL chain_result: got %h expected %h", m_data, c2_m); end
    take_out();
    chain_m = c2_m;
  endtask

  task automatic test_decrypt();
    bit ok, seen, cvo_prev;
    iv = 64'd0;
    iv_load = 1'b1;
    s_valid = 1'b1;
    #1;
    checks++;
    if (s_ready !== !CBC) begin errors++; $display("FAIL ivload_ready: got %b expected %b", s_ready, !CBC); end
    s_valid = 1'b0;
    tick();
    iv_load = 1'b0;
    chain_m = 64'd0;
    send_block(C1, 1'b1, ok);
    checks++;
    if ({core_encrypt_decrypt, core_plain_text} !== {1'b1, C1}) begin
      errors++;
      $display("FAIL dec1_issue: got %b %h expected 1 %h", core_encrypt_decrypt, core_plain_text, C1);
    end
    wait_out(seen, cvo_prev);
    checks++;
    if (!seen || m_data !== P) begin errors++; $display("FAIL dec1_result: got %h expected %h", m_data, P); end
    take_out();
    send_block(c2_m, 1'b1, ok);
    wait_out(seen, cvo_prev);
    checks++;
    if (!seen || m_data !== P) begin errors++; $display("FAIL dec2_result: got %h expected %h", m_data, P); end
    take_out();
    chain_m = c2_m;
  endtask

  task automatic test_stall();
    bit ok, seen, cvo_prev, bad;
    logic [63:0] exp_in, exp_out;
    exp_in = CBC ? (P ^ chain_m) : P;
    send_block(P, 1'b0, ok);
    wait_out(seen, cvo_prev);
    exp_out = stub_enc(exp_in);
    checks++;
    if (!seen || m_data !== exp_out) begin errors++; $display("FAIL stall_result: got %h expected %h", m_data, exp_out); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || m_data !== exp_out || s_ready !== 1'b0) bad = 1'b1;
      if (i == 4) begin iv = 64'hFFFF_FFFF_FFFF_FFFF; iv_load = 1'b1; end
      if (i == 5) iv_load = 1'b0;
      tick();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL stall_hold: got unstable output expected stable %h", exp_out); end
    take_out();
    chain_m = exp_out;
    exp_in = CBC ? (P ^ chain_m) : P;
    send_block(P, 1'b0, ok);
    checks++;
    if (core_plain_text !== exp_in) begin errors++; $display("FAIL stall_chain_kept: got %h expected %h", core_plain_text, exp_in); end
    wait_out(seen, cvo_prev);
    take_out();
    chain_m = stub_enc(exp_in);
  endtask

  task automatic test_watchdog();
    bit ok;
    stub_en = 1'b0;
    send_block(P, 1'b0, ok);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b expected 0", err); end
      end
      if (k == 8) begin
        checks++;
        if ({err, s_ready, m_valid} !== 3'b110) begin
          errors++;
          $display("FAIL wdog_fire: got %b expected 110", {err, s_ready, m_valid});
        end
      end
    end
    stub_en = 1'b1;
    iv = 64'd0;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    chain_m = 64'd0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    send_block(P, 1'b0, ok);
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready, core_valid_in, m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_assert: got %b expected 000", {s_ready, core_valid_in, m_valid});
    end
    tick();
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_stale: got m_valid 1 expected 0"); end
    checks++;
    if ({s_ready, err} !== 2'b10) begin errors++; $display("FAIL midreset_idle: got %b expected 10", {s_ready, err}); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_chain();
    test_decrypt();
    test_stall();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
